// File: rtl/imem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_responder_if
// Description : Fetch request/response and program-load bundle for the
//               instruction memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_responder_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_instr;
    logic [31:0] resp_addr;
    logic        resp_err;
    logic        flush;
    logic        load_we;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    modport master (
        output req_valid, req_addr, resp_ready, flush,
               load_we, load_addr, load_data,
        input  req_ready, resp_valid, resp_instr, resp_addr, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready, flush,
               load_we, load_addr, load_data,
        output req_ready, resp_valid, resp_instr, resp_addr, resp_err
    );
endinterface
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : imem_responder
// Description : Instruction memory with a fixed-latency fetch port, one
//               outstanding request, flush support and a program-load port.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
    input wire             clk,
    input wire             rst,
    imem_responder_if.slave bus
);
    localparam int         c_IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [30:0] c_DEPTH_31 = 31'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // LATENCY=1 skips BUSY entirely; otherwise BUSY runs LATENCY-1 cycles.
    localparam state_t     c_ACCEPT_STATE = (LATENCY == 1) ? S_HOLD : S_BUSY;
    localparam logic [1:0] c_CNT_INIT     = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

    state_t               r_state;
    state_t               w_state_next;
    logic [1:0]           r_cnt;
    logic [1:0]           w_cnt_next;
    logic [31:0]          r_resp_instr;
    logic [31:0]          r_resp_addr;
    logic                 r_resp_err;
    logic [31:0]          r_mem [DEPTH_WORDS];

    logic                 w_req_ready;
    logic                 w_accept;
    logic                 w_req_err;
    logic                 w_load_ok;
    logic [c_IDX_W-1:0]   w_req_idx;
    logic [c_IDX_W-1:0]   w_load_idx;

    assign w_req_idx  = bus.req_addr[c_IDX_W+1:2];
    assign w_load_idx = bus.load_addr[c_IDX_W+1:2];
    assign w_req_err  = (bus.req_addr[1:0] != 2'b00) ||
                        ({1'b0, bus.req_addr[31:2]} >= c_DEPTH_31);
    assign w_load_ok  = (bus.load_addr[1:0] == 2'b00) &&
                        ({1'b0, bus.load_addr[31:2]} < c_DEPTH_31);

    assign w_req_ready = !bus.flush &&
                         ((r_state == S_IDLE) || ((r_state == S_HOLD) && bus.resp_ready));
    assign w_accept    = bus.req_valid && w_req_ready;

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = (r_state == S_HOLD);
    assign bus.resp_instr = r_resp_instr;
    assign bus.resp_addr  = r_resp_addr;
    assign bus.resp_err   = r_resp_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (bus.flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_state_next = c_ACCEPT_STATE;
                        w_cnt_next   = c_CNT_INIT;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 2'd0) begin
                        w_state_next = S_HOLD;
                    end else begin
                        w_cnt_next = r_cnt - 2'd1;
                    end
                end
                S_HOLD: begin
                    if (w_accept) begin
                        w_state_next = c_ACCEPT_STATE;
                        w_cnt_next   = c_CNT_INIT;
                    end else if (bus.resp_ready) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Response fields only move on accept, so they stay frozen while held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_instr <= NOP_INSTR;
            r_resp_addr  <= 32'd0;
            r_resp_err   <= 1'b0;
        end else if (w_accept) begin
            r_resp_addr  <= bus.req_addr;
            r_resp_err   <= w_req_err;
            r_resp_instr <= w_req_err ? NOP_INSTR : r_mem[w_req_idx];
        end
    end

    // No reset on the array: program contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst && bus.load_we && w_load_ok) begin
            r_mem[w_load_idx] <= bus.load_data;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_responder
// Description : Scoreboard bench for imem_responder at LATENCY 1 and 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_responder;
    localparam int          c_DEPTH = 64;
    localparam logic [31:0] c_NOP   = 32'h00000013;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_responder_if bus1();
    imem_responder_if bus3();

    imem_responder #(.DEPTH_WORDS(c_DEPTH), .LATENCY(1), .NOP_INSTR(c_NOP)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    imem_responder #(.DEPTH_WORDS(c_DEPTH), .LATENCY(3), .NOP_INSTR(c_NOP)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
        int          due;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    exp_t        sbq [2][$];
    logic [31:0] e_instr [2];
    logic        e_err   [2];
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    int          cyc       = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Per-DUT model: queue empty = idle, head not yet due = busy, due = held.
    task automatic sb(input int d, input int lat,
                      input logic rv_o, input logic rdy_o,
                      input logic [31:0] ri, input logic [31:0] ra, input logic re,
                      input logic qv, input logic [31:0] qa,
                      input logic rr, input logic fl);
        logic ev, er;
        ev = (sbq[d].size() > 0) && (sbq[d][0].due <= cyc);
        er = !fl && ((sbq[d].size() == 0) || (ev && rr));
        check($sformatf("d%0d resp_valid", d), 32'(rv_o), 32'(ev));
        check($sformatf("d%0d req_ready", d), 32'(rdy_o), 32'(er));
        if (ev) begin
            check($sformatf("d%0d resp_instr", d), ri, sbq[d][0].instr);
            check($sformatf("d%0d resp_addr", d), ra, sbq[d][0].addr);
            check($sformatf("d%0d resp_err", d), 32'(re), 32'(sbq[d][0].err));
        end
        if (rst || fl) begin
            sbq[d].delete();
        end else begin
            if (ev && rr) void'(sbq[d].pop_front());
            if (qv && er) sbq[d].push_back('{qa, e_instr[d], e_err[d], cyc + lat});
        end
    endtask

    task automatic tick();
        #1;
        sb(0, 1, bus1.resp_valid, bus1.req_ready, bus1.resp_instr, bus1.resp_addr,
           bus1.resp_err, bus1.req_valid, bus1.req_addr, bus1.resp_ready, bus1.flush);
        sb(1, 3, bus3.resp_valid, bus3.req_ready, bus3.resp_instr, bus3.resp_addr,
           bus3.resp_err, bus3.req_valid, bus3.req_addr, bus3.resp_ready, bus3.flush);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] dat);
        bus1.load_we = 1'b1; bus1.load_addr = a; bus1.load_data = dat;
        bus3.load_we = 1'b1; bus3.load_addr = a; bus3.load_data = dat;
        tick();
        bus1.load_we = 1'b0;
        bus3.load_we = 1'b0;
    endtask

    task automatic fetch1(input logic [31:0] a, input logic [31:0] ins, input logic er, input logic rr);
        bus1.req_valid = 1'b1; bus1.req_addr = a; bus1.resp_ready = rr;
        e_instr[0] = ins; e_err[0] = er;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " resp_valid"}, 32'(bus1.resp_valid), 32'd0);
        check({tag, " resp_instr"}, bus1.resp_instr, c_NOP);
        check({tag, " resp_addr"},  bus1.resp_addr, 32'd0);
        check({tag, " resp_err"},   32'(bus1.resp_err), 32'd0);
        check({tag, " d3 resp_valid"}, 32'(bus3.resp_valid), 32'd0);
        check({tag, " d3 resp_instr"}, bus3.resp_instr, c_NOP);
    endtask

    vec_t loads [6];
    vec_t vecs  [8];

    initial begin
        loads[0] = '{32'h0000_0000, 32'h0050_0093, 1'b0};
        loads[1] = '{32'h0000_0004, 32'h00A0_0113, 1'b0};
        loads[2] = '{32'h0000_0008, 32'h0020_81B3, 1'b0};
        loads[3] = '{32'h0000_000C, 32'hDEAD_BEEF, 1'b0};
        loads[4] = '{32'h0000_0006, 32'hBAD0_BAD0, 1'b0};
        loads[5] = '{32'(c_DEPTH * 4), 32'hBAD1_BAD1, 1'b0};

        vecs[0] = '{32'h0000_0000, 32'h0050_0093, 1'b0};
        vecs[1] = '{32'h0000_0004, 32'h00A0_0113, 1'b0};
        vecs[2] = '{32'h0000_0008, 32'h0020_81B3, 1'b0};
        vecs[3] = '{32'h0000_000C, 32'hDEAD_BEEF, 1'b0};
        vecs[4] = '{32'h0000_0002, c_NOP,         1'b1};
        vecs[5] = '{32'(c_DEPTH * 4), c_NOP,      1'b1};
        vecs[6] = '{32'hFFFF_FFFC, c_NOP,         1'b1};
        vecs[7] = '{32'h0000_0004, 32'h00A0_0113, 1'b0};

        rst = 1'b1;
        bus1.req_valid = 0; bus1.req_addr = 0; bus1.resp_ready = 0; bus1.flush = 0;
        bus1.load_we = 0; bus1.load_addr = 0; bus1.load_data = 0;
        bus3.req_valid = 0; bus3.req_addr = 0; bus3.resp_ready = 0; bus3.flush = 0;
        bus3.load_we = 0; bus3.load_addr = 0; bus3.load_data = 0;
        e_instr[0] = c_NOP; e_err[0] = 1'b0; e_instr[1] = c_NOP; e_err[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 6; i++) load(loads[i].addr, loads[i].instr);

        // Streaming at LATENCY=1, including error addresses.
        for (int i = 0; i < 8; i++) begin
            fetch1(vecs[i].addr, vecs[i].instr, vecs[i].err, 1'b1);
            tick();
        end
        bus1.req_valid = 1'b0;
        tick();
        tick();

        // Stall in HOLD on 0x4 with 0x8 waiting.
        fetch1(32'h4, 32'h00A0_0113, 1'b0, 1'b1);
        tick();
        fetch1(32'h8, 32'h0020_81B3, 1'b0, 1'b0);
        repeat (3) tick();
        bus1.resp_ready = 1'b1;
        tick();
        bus1.req_valid = 1'b0;
        tick();
        tick();

        // Load and fetch of the same word in one cycle: old data, then new.
        fetch1(32'hC, 32'hDEAD_BEEF, 1'b0, 1'b1);
        load(32'hC, 32'h1234_5678);
        fetch1(32'hC, 32'h1234_5678, 1'b0, 1'b1);
        tick();
        bus1.req_valid = 1'b0;
        tick();

        // Flush while a response is held: visible in the flush cycle, then gone.
        fetch1(32'h0, 32'h0050_0093, 1'b0, 1'b0);
        tick();
        bus1.req_valid = 1'b0; bus1.flush = 1'b1; bus1.resp_ready = 1'b1;
        tick();
        bus1.flush = 1'b0;
        tick();

        // LATENCY=3 latency, then flush one cycle after accept with a competing request.
        bus3.req_valid = 1'b1; bus3.req_addr = 32'h4; bus3.resp_ready = 1'b1;
        e_instr[1] = 32'h00A0_0113; e_err[1] = 1'b0;
        tick();
        bus3.req_valid = 1'b0;
        repeat (4) tick();
        bus3.req_valid = 1'b1; bus3.req_addr = 32'h8;
        e_instr[1] = 32'h0020_81B3;
        tick();
        bus3.req_addr = 32'h40; bus3.flush = 1'b1;
        e_instr[1] = c_NOP;
        tick();
        bus3.req_valid = 1'b0; bus3.flush = 1'b0;
        repeat (4) tick();

        // Reset while holding; a load in the reset cycle must not land.
        fetch1(32'h4, 32'h00A0_0113, 1'b0, 1'b0);
        tick();
        bus1.req_valid = 1'b0;
        rst = 1'b1;
        bus1.load_we = 1'b1; bus1.load_addr = 32'h0; bus1.load_data = 32'hFFFF_FFFF;
        tick();
        rst = 1'b0;
        bus1.load_we = 1'b0;
        check_reset_outputs("post-reset");
        fetch1(32'h0, 32'h0050_0093, 1'b0, 1'b1);
        tick();
        fetch1(32'h8, 32'h0020_81B3, 1'b0, 1'b1);
        tick();
        bus1.req_valid = 1'b0;
        tick();
        tick();

        check("d1 drained", 32'(sbq[0].size()), 32'd0);
        check("d3 drained", 32'(sbq[1].size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
`default_nettype wire
